idct_2d: RTL and testbench

Two-dimensional 8×8 inverse DCT engine for the JPEG decoder datapath. It sits after dequantization and before colour conversion. It accepts one block of 64 signed 8-bit dequantized coefficients in a single beat. It returns 64 unsigned 8-bit level-shifted, clamped samples in a single beat, using an iterative row-then-column separable computation.

---
 rtl/idct_pkg.sv | 70 +++++++
 rtl/idct_1d8.sv | 24 ++
 rtl/idct_2d.sv | 90 +++++++++
 tb/tb_idct_2d.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared constants, state encoding and helpers for the 8x8 inverse DCT engine.
// Cosine constants are Q12 (4096 = 1.0) and already include the 0.5*c_u scale.
package idct_pkg;

  localparam int ROUND = 2048;
  localparam int SHIFT = 12;
  localparam int LEVEL = 128;

  typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_t;

  typedef logic signed [12:0]       coef_t;
  typedef logic [7:0][7:0][12:0]    cos_mat_t;

  // 2048*cos(k*pi/16), folded into the first quadrant with the matching sign
  function automatic coef_t cos_q12(input int k);
    int    m;
    int    r;
    logic  neg;
    coef_t mag;
    m = k % 32;
    if (m <= 8) begin
      r = m;      neg = 1'b0;
    end else if (m <= 16) begin
      r = 16 - m; neg = 1'b1;
    end else if (m <= 24) begin
      r = m - 16; neg = 1'b1;
    end else begin
      r = 32 - m; neg = 1'b0;
    end
    case (r)
      0:       mag = 13'sd2048;
      1:       mag = 13'sd2009;
      2:       mag = 13'sd1892;
      3:       mag = 13'sd1703;
      4:       mag = 13'sd1448;
      5:       mag = 13'sd1138;
      6:       mag = 13'sd784;
      7:       mag = 13'sd400;
      default: mag = 13'sd0;
    endcase
    return neg ? -mag : mag;
  endfunction

  function automatic coef_t idct_coef(input int n, input int u);
    if (u == 0) return 13'sd1448;
    return cos_q12((2 * n + 1) * u);
  endfunction

  function automatic cos_mat_t build_cos_mat();
    cos_mat_t m;
    for (int n = 0; n < 8; n++)
      for (int u = 0; u < 8; u++)
        m[n][u] = idct_coef(n, u);
    return m;
  endfunction

  localparam cos_mat_t COS_MAT = build_cos_mat();

  // Level shift back to unsigned pixels and saturate to 0..255
  function automatic logic [7:0] level_clamp(input logic [15:0] v);
    logic signed [16:0] s;
    s = 17'($signed(v)) + 17'(LEVEL);
    if (s < 17'sd0)
      return 8'd0;
    else if (s > 17'sd255)
      return 8'hff;
    return s[7:0];
  endfunction

endpackage

// File: rtl/idct_1d8.sv
// Combinational 8-point 1-D IDCT with Q12 constants and round-half-up output.
// Shared by the row and column passes of idct_2d.
module idct_1d8
  import idct_pkg::*;
(
  input  logic [7:0][15:0] in_vec,
  output logic [7:0][15:0] out_vec
);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_out
      logic signed [31:0] acc;

      always_comb begin
        acc = ROUND;
        for (int u = 0; u < 8; u++)
          acc = acc + 32'($signed(in_vec[u])) * 32'($signed(COS_MAT[gi][u]));
      end

      assign out_vec[gi] = 16'(acc >>> SHIFT);
    end
  endgenerate

endmodule

// File: rtl/idct_2d.sv
// 8x8 inverse DCT: one block in, eight row beats, eight column beats, one block out.
// A single idct_1d8 is time-shared between the passes through an input mux.
module idct_2d
  import idct_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  input  logic [511:0] data_in,
  output logic [511:0] data_out,
  output logic         m_valid
);

  state_t                 state_reg, state_next;
  logic [2:0]             idx_reg;
  logic [511:0]           in_reg;
  logic [7:0][7:0][15:0]  tbuf_reg;
  logic [7:0][7:0][7:0]   pix_reg;

  logic capture, row_we, col_we, out_load;
  logic [7:0][15:0] tr_in, tr_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (s_valid) state_next = ROW;
      ROW:     if (idx_reg == 3'd7) state_next = COL;
      COL:     if (idx_reg == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture  = 1'b0;
    row_we   = 1'b0;
    col_we   = 1'b0;
    out_load = 1'b0;
    case (state_reg)
      IDLE:    capture  = s_valid;
      ROW:     row_we   = 1'b1;
      COL:     col_we   = 1'b1;
      DONE:    out_load = 1'b1;
      default: ;
    endcase
  end

  // Row pass reads sign-extended coefficients; column pass reads a buffer column
  always_comb begin
    for (int u = 0; u < 8; u++) begin
      if (state_reg == COL)
        tr_in[u] = tbuf_reg[u][idx_reg];
      else
        tr_in[u] = 16'($signed(in_reg[(32'(idx_reg) * 8 + u) * 8 +: 8]));
    end
  end

  idct_1d8 u_idct_1d8 (
    .in_vec  (tr_in),
    .out_vec (tr_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg  <= 3'd0;
      in_reg   <= '0;
      tbuf_reg <= '0;
      pix_reg  <= '0;
      data_out <= '0;
      m_valid  <= 1'b0;
    end else begin
      m_valid <= out_load;
      if (row_we || col_we) idx_reg <= idx_reg + 3'd1;
      else                  idx_reg <= 3'd0;
      if (capture) in_reg <= data_in;
      if (row_we)  tbuf_reg[idx_reg] <= tr_out;
      if (col_we) begin
        for (int y = 0; y < 8; y++)
          pix_reg[y][idx_reg] <= level_clamp(tr_out[y]);
      end
      if (out_load) data_out <= pix_reg;
    end
  end

endmodule

// File: tb/tb_idct_2d.sv
// Self-checking bench for idct_2d: directed and random blocks against a
// floating-point-derived Q12 reference, plus latency and protocol checks.
module tb_idct_2d;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic [511:0] data_in;
  logic [511:0] data_out;
  logic         m_valid;

  int n_checks = 0;
  int n_errors = 0;
  int coef_m[8][8];

  always #5 clk = ~clk;

  idct_2d dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .data_in  (data_in),
    .data_out (data_out),
    .m_valid  (m_valid)
  );

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void build_coefs();
    real cu, v;
    for (int n = 0; n < 8; n++)
      for (int u = 0; u < 8; u++) begin
        cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        v  = 2048.0 * cu * $cos((2 * n + 1) * u * 3.14159265358979 / 16.0);
        coef_m[n][u] = int'($floor(v + 0.5));
      end
  endfunction

  function automatic logic [511:0] ref_idct(input logic [511:0] din);
    longint t[8][8];
    longint acc, p;
    logic [511:0] res;
    res = '0;
    for (int r = 0; r < 8; r++)
      for (int n = 0; n < 8; n++) begin
        acc = 2048;
        for (int u = 0; u < 8; u++)
          acc += longint'(coef_m[n][u]) * longint'($signed(din[(r * 8 + u) * 8 +: 8]));
        t[r][n] = acc >>> 12;
      end
    for (int c = 0; c < 8; c++)
      for (int y = 0; y < 8; y++) begin
        acc = 2048;
        for (int v = 0; v < 8; v++)
          acc += longint'(coef_m[y][v]) * t[v][c];
        p = (acc >>> 12) + 128;
        if (p < 0)   p = 0;
        if (p > 255) p = 255;
        res[(y * 8 + c) * 8 +: 8] = 8'(p);
      end
    return res;
  endfunction

  task automatic send(input logic [511:0] blk);
    @(negedge clk);
    data_in = blk;
    s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(input int limit, output int edges);
    edges = 0;
    while (edges < limit) begin
      @(posedge clk);
      #1;
      edges++;
      if (m_valid) break;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [511:0] blk);
    int n;
    send(blk);
    wait_mvalid(40, n);
    check_eq({tag, "_latency"}, 512'(n), 512'(17));
    check_eq({tag, "_data"}, data_out, ref_idct(blk));
    $display("block %s: latency=%0d sample0=%0d", tag, n, data_out[7:0]);
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, 512'(m_valid), 512'(0));
  endtask

  initial begin
    logic [511:0] blk, blk_b, got;
    logic [7:0] p0, px, pr;
    logic ok_rows, ok_side, ok_sym;
    int n, cnt, s;

    build_coefs();
    rst = 1'b1; s_valid = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_mvalid", 512'(m_valid), 512'(0));
    check_eq("reset_data", data_out, '0);
    @(negedge clk);
    rst = 1'b0;

    run_and_check("zero", '0);
    check_eq("zero_const", data_out, {64{8'd128}});

    blk = '0; blk[7:0] = 8'(-80);
    run_and_check("dc_neg", blk);
    check_eq("dc_neg_const", data_out, {64{8'd118}});
    blk[7:0] = 8'd80;
    run_and_check("dc_pos", blk);
    check_eq("dc_pos_const", data_out, {64{8'd138}});

    blk = '0;
    blk[0*8 +: 8]  = 8'(-80); blk[2*8 +: 8]  = 8'(-10); blk[8*8 +: 8]  = 8'd24;
    blk[9*8 +: 8]  = 8'(-12); blk[10*8 +: 8] = 8'd14;   blk[16*8 +: 8] = 8'(-14);
    blk[17*8 +: 8] = 8'(-13);
    run_and_check("sparse", blk);

    run_and_check("clamp_lo", {64{8'h80}});
    check_eq("clamp_lo_s0", 512'(data_out[7:0]), 512'(0));
    run_and_check("clamp_hi", {64{8'h7f}});
    check_eq("clamp_hi_s0", 512'(data_out[7:0]), 512'(255));

    blk = '0; blk[1*8 +: 8] = 8'd64;
    run_and_check("hac", blk);
    ok_rows = 1'b1; ok_side = 1'b1; ok_sym = 1'b1;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        px = data_out[(y * 8 + x) * 8 +: 8];
        p0 = data_out[x * 8 +: 8];
        pr = data_out[(y * 8 + 7 - x) * 8 +: 8];
        if (px != p0) ok_rows = 1'b0;
        if ((x < 4) ? (px <= 8'd128) : (px >= 8'd128)) ok_side = 1'b0;
        s = int'(px) + int'(pr);
        if (s < 255 || s > 257) ok_sym = 1'b0;
      end
    check_eq("hac_rows", 512'(ok_rows), 512'(1));
    check_eq("hac_side", 512'(ok_side), 512'(1));
    check_eq("hac_sym", 512'(ok_sym), 512'(1));

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 64; k++)
        blk[k * 8 +: 8] = (i % 2 == 1) ? 8'($urandom) : 8'(int'($urandom_range(0, 40)) - 20);
      run_and_check($sformatf("rand%0d", i), blk);
    end

    // s_valid held high: back-to-back blocks every 18 cycles
    for (int k = 0; k < 64; k++) blk[k * 8 +: 8] = 8'(int'($urandom_range(0, 60)) - 30);
    @(negedge clk);
    data_in = blk; s_valid = 1'b1;
    wait_mvalid(40, n);
    check_eq("held_first", 512'(n), 512'(18));
    wait_mvalid(40, n);
    check_eq("held_period", 512'(n), 512'(18));
    check_eq("held_data", data_out, ref_idct(blk));
    $display("held: period=%0d", n);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (40) @(posedge clk);

    // Pulse during the column pass is dropped
    for (int k = 0; k < 64; k++) blk_b[k * 8 +: 8] = 8'($urandom);
    send(blk);
    repeat (10) @(negedge clk);
    data_in = blk_b; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    cnt = 0; got = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (m_valid) begin cnt++; got = data_out; end
    end
    check_eq("colpulse_count", 512'(cnt), 512'(1));
    check_eq("colpulse_data", got, ref_idct(blk));
    $display("col pulse: m_valid count=%0d", cnt);

    // Reset mid-block aborts it
    send(blk_b);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_mvalid", 512'(m_valid), 512'(0));
    check_eq("abort_data", data_out, '0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (m_valid) cnt++;
    end
    check_eq("abort_silent", 512'(cnt), 512'(0));
    check_eq("abort_hold", data_out, '0);
    $display("reset abort: m_valid count=%0d", cnt);
    run_and_check("after_abort", blk_b);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
